// File: rtl/sha_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sha_run_sequencer
// Purpose  : Go/finish run sequencer for the SHA256 accelerator. Runs a batch
//            of back-to-back hash runs against MyDesign, driving go and
//            msg_length and watching finish. Each run's latency is measured
//            from the go cycle to the first sampled finish=1. A run that does
//            not complete within TIMEOUT cycles is aborted and flagged.
//            Go waveform per run is selected by the latched mode:
//              0 SINGLE : one-cycle go pulse
//              1 RETRIG : go pulse, then a second go window of RETRIG_HOLD
//                         cycles starting RETRIG_DELAY cycles after the first
//              2 HOLD   : go held from the go cycle until the run ends
//              3        : reserved, behaves as SINGLE
// Ports    : clk, reset (sync, active-high)
//            cfg_start/cfg_mode/cfg_num_runs/cfg_msg_length/cfg_gap
//                        batch configuration, captured on cfg_start in IDLE
//            dut_finish  finish from the accelerator
//            go, msg_length  drive to the accelerator
//            busy        batch in progress
//            run_done/run_id/run_cycles/run_timeout  per-run report
//            batch_done  one-cycle pulse once every run has completed
// Revision : 1.0  initial release
// ============================================================================
module sha_run_sequencer #(
    parameter int MAX_MESSAGE_LENGTH = 55,
    parameter int RUN_W              = 8,
    parameter int CYC_W              = 16,
    parameter int TIMEOUT            = 1000,
    parameter int RETRIG_DELAY       = 10,
    parameter int RETRIG_HOLD        = 10,
    parameter int ML_W               = $clog2(MAX_MESSAGE_LENGTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [1:0]       cfg_mode,
    input  logic [RUN_W-1:0] cfg_num_runs,
    input  logic [ML_W-1:0]  cfg_msg_length,
    input  logic [7:0]       cfg_gap,
    input  logic             dut_finish,
    output logic             go,
    output logic [ML_W-1:0]  msg_length,
    output logic             busy,
    output logic             run_done,
    output logic [RUN_W-1:0] run_id,
    output logic [CYC_W-1:0] run_cycles,
    output logic             run_timeout,
    output logic             batch_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_GO        = 3'd1;
    localparam logic [2:0] c_ST_WAIT_LOW  = 3'd2;
    localparam logic [2:0] c_ST_WAIT_HIGH = 3'd3;
    localparam logic [2:0] c_ST_GAP       = 3'd4;
    localparam logic [2:0] c_ST_DONE      = 3'd5;

    localparam logic [1:0] c_MODE_RETRIG  = 2'd1;
    localparam logic [1:0] c_MODE_HOLD    = 2'd2;

    localparam logic [CYC_W-1:0] c_CNT_MAX    = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] c_TIMEOUT    = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0] c_TIMEOUT_M1 = CYC_W'(TIMEOUT - 1);
    localparam logic [CYC_W-1:0] c_RT_START   = CYC_W'(RETRIG_DELAY);
    localparam logic [CYC_W-1:0] c_RT_END     = CYC_W'(RETRIG_DELAY + RETRIG_HOLD);

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [1:0]       r_mode;
    logic [RUN_W-1:0] r_num_runs;
    logic [7:0]       r_gap;
    logic [7:0]       r_gap_cnt;
    logic [CYC_W-1:0] r_cnt;

    logic             r_go;
    logic [ML_W-1:0]  r_msg_length;
    logic             r_busy;
    logic             r_run_done;
    logic [RUN_W-1:0] r_run_id;
    logic [CYC_W-1:0] r_run_cycles;
    logic             r_run_timeout;
    logic             r_batch_done;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [CYC_W-1:0] w_cnt_inc;
    logic             w_in_wait;
    logic             w_finish_hit;
    logic             w_timeout_hit;
    logic             w_run_end;
    logic             w_go_wait;
    logic             w_last_run;
    logic [7:0]       w_gap_load;

    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    assign w_in_wait = (r_state == c_ST_WAIT_LOW) || (r_state == c_ST_WAIT_HIGH);

    // Completion only counts once finish has been seen low, i.e. in WAIT_HIGH.
    assign w_finish_hit = (r_state == c_ST_WAIT_HIGH) && dut_finish;

    // A finish arriving on the last allowed cycle beats the timeout.
    assign w_timeout_hit = w_in_wait && (r_cnt == c_TIMEOUT_M1) && !w_finish_hit;

    assign w_run_end = w_finish_hit || w_timeout_hit;

    // go level for the next cycle while the run is still in progress. The
    // retrigger window is evaluated on the count the next cycle will carry so
    // that go is high exactly while cnt is in [DELAY, DELAY+HOLD).
    assign w_go_wait = (r_mode == c_MODE_HOLD) ||
                       ((r_mode == c_MODE_RETRIG) &&
                        (w_cnt_inc >= c_RT_START) && (w_cnt_inc < c_RT_END));

    // GAP is only reached with at least one run configured.
    assign w_last_run = (r_run_id == (r_num_runs - 1'b1));

    // A zero gap still spends one cycle in GAP.
    assign w_gap_load = (r_gap == 8'd0) ? 8'd1 : r_gap;

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_mode        <= 2'd0;
            r_num_runs    <= '0;
            r_gap         <= 8'd0;
            r_gap_cnt     <= 8'd0;
            r_cnt         <= '0;
            r_go          <= 1'b0;
            r_msg_length  <= '0;
            r_busy        <= 1'b0;
            r_run_done    <= 1'b0;
            r_run_id      <= '0;
            r_run_cycles  <= '0;
            r_run_timeout <= 1'b0;
            r_batch_done  <= 1'b0;
        end else begin
            r_run_done   <= 1'b0;
            r_batch_done <= 1'b0;

            // Free-running latency counter; entry into GO overrides with 0.
            if (r_state != c_ST_IDLE) begin
                r_cnt <= w_cnt_inc;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (cfg_start) begin
                        r_mode       <= cfg_mode;
                        r_num_runs   <= cfg_num_runs;
                        r_gap        <= cfg_gap;
                        r_msg_length <= cfg_msg_length;
                        r_run_id     <= '0;
                        r_busy       <= 1'b1;
                        if (cfg_num_runs == '0) begin
                            r_state      <= c_ST_DONE;
                            r_batch_done <= 1'b1;
                        end else begin
                            r_state <= c_ST_GO;
                            r_go    <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                end

                c_ST_GO: begin
                    r_state <= c_ST_WAIT_LOW;
                    r_go    <= w_go_wait;
                end

                c_ST_WAIT_LOW,
                c_ST_WAIT_HIGH: begin
                    if (w_run_end) begin
                        r_go          <= 1'b0;
                        r_run_done    <= 1'b1;
                        r_run_cycles  <= w_finish_hit ? r_cnt : c_TIMEOUT;
                        r_run_timeout <= !w_finish_hit;
                        r_gap_cnt     <= w_gap_load;
                        r_state       <= c_ST_GAP;
                    end else begin
                        r_go <= w_go_wait;
                        // A finish still high from the previous run is ignored
                        // until it has been seen low.
                        if ((r_state == c_ST_WAIT_LOW) && !dut_finish) begin
                            r_state <= c_ST_WAIT_HIGH;
                        end
                    end
                end

                c_ST_GAP: begin
                    if (r_gap_cnt == 8'd1) begin
                        if (w_last_run) begin
                            r_state      <= c_ST_DONE;
                            r_batch_done <= 1'b1;
                        end else begin
                            r_run_id <= r_run_id + 1'b1;
                            r_state  <= c_ST_GO;
                            r_go     <= 1'b1;
                            r_cnt    <= '0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end

                c_ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_go    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign go          = r_go;
    assign msg_length  = r_msg_length;
    assign busy        = r_busy;
    assign run_done    = r_run_done;
    assign run_id      = r_run_id;
    assign run_cycles  = r_run_cycles;
    assign run_timeout = r_run_timeout;
    assign batch_done  = r_batch_done;

endmodule
`default_nettype wire
